// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: ExcCode values, exc_flags bit positions and the
// exception-controller state encoding.
package cpu_defs_pkg;

  localparam int unsigned EXC_INT  = 0;
  localparam int unsigned EXC_ADEL = 4;
  localparam int unsigned EXC_ADES = 5;
  localparam int unsigned EXC_SYS  = 8;
  localparam int unsigned EXC_BP   = 9;
  localparam int unsigned EXC_RI   = 10;
  localparam int unsigned EXC_OV   = 12;
  localparam int unsigned EXC_TR   = 13;

  // exc_flags = {eret, adel_if, ri, syscall, brk, ov, adel_d, ades}
  localparam int unsigned NUM_FLAGS   = 8;
  localparam int unsigned FLG_ADES    = 0;
  localparam int unsigned FLG_ADEL_D  = 1;
  localparam int unsigned FLG_OV      = 2;
  localparam int unsigned FLG_BRK     = 3;
  localparam int unsigned FLG_SYSCALL = 4;
  localparam int unsigned FLG_RI      = 5;
  localparam int unsigned FLG_ADEL_IF = 6;
  localparam int unsigned FLG_ERET    = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational exception priority encoder; the trap source exists only
// when EXC_TRAP_EN is defined.
module exc_prio_enc
  import cpu_defs_pkg::*;
#(
  parameter int unsigned EXC_W = 5
) (
  input  logic [7:0]       flags,
  input  logic             int_pend,
`ifdef EXC_TRAP_EN
  input  logic             trap,
`endif
  output logic             hit,
  output logic             is_eret,
  output logic [EXC_W-1:0] code,
  output logic             use_badv_d
);

  always_comb begin
    hit        = 1'b1;
    is_eret    = 1'b0;
    code       = '0;
    use_badv_d = 1'b0;
    if (int_pend)                  code = EXC_W'(EXC_INT);
    else if (flags[FLG_ADEL_IF])   code = EXC_W'(EXC_ADEL);
    else if (flags[FLG_RI])        code = EXC_W'(EXC_RI);
    else if (flags[FLG_OV])        code = EXC_W'(EXC_OV);
`ifdef EXC_TRAP_EN
    else if (trap)                 code = EXC_W'(EXC_TR);
`endif
    else if (flags[FLG_SYSCALL])   code = EXC_W'(EXC_SYS);
    else if (flags[FLG_BRK])       code = EXC_W'(EXC_BP);
    else if (flags[FLG_ADEL_D]) begin
      code       = EXC_W'(EXC_ADEL);
      use_badv_d = 1'b1;
    end else if (flags[FLG_ADES]) begin
      code       = EXC_W'(EXC_ADES);
      use_badv_d = 1'b1;
    end else if (flags[FLG_ERET])  is_eret = 1'b1;
    else                           hit = 1'b0;
  end

endmodule

// File: rtl/exc_ctrl.sv
// Registered MEM/WB exception controller: prioritises, holds across stalls,
// commits one exception or ERET. Optional macro EXC_TRAP_EN adds trap/int_timer.
module exc_ctrl
  import cpu_defs_pkg::*;
#(
  parameter int unsigned NUM_INT = 8,
  parameter logic [31:0] EXC_VEC = 32'hBFC00380,
  parameter int unsigned EXC_W   = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inst_valid,
  input  logic             stall,
  input  logic [31:0]      pc,
  input  logic             in_ds,
  input  logic [7:0]       exc_flags,
  input  logic [31:0]      bad_addr_d,
  input  logic [31:0]      cp0_status,
  input  logic [31:0]      cp0_cause,
  input  logic [31:0]      cp0_epc,
`ifdef EXC_TRAP_EN
  input  logic             trap,
  input  logic             int_timer,
`endif
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             cp0_we,
  output logic [EXC_W-1:0] exccode,
  output logic [31:0]      epc_o,
  output logic [31:0]      badvaddr_o,
  output logic             badv_we,
  output logic             bd_o,
  output logic             eret_o
);

  state_t           state_q, state_d;
  logic             int_pend_q, int_pend_d;
  logic             blank_q, blank_d;
  logic             lat_eret_q, lat_eret_d;
  logic [EXC_W-1:0] lat_code_q, lat_code_d;
  logic [31:0]      lat_epc_q, lat_epc_d;
  logic [31:0]      lat_badv_q, lat_badv_d;
  logic             lat_badv_we_q, lat_badv_we_d;
  logic             lat_bd_q, lat_bd_d;
  logic             flush_q, flush_d;
  logic             cp0_we_q, cp0_we_d;
  logic             eret_q, eret_d;
  logic [EXC_W-1:0] exccode_q, exccode_d;
  logic [31:0]      epc_q, epc_d;
  logic [31:0]      badvaddr_q, badvaddr_d;
  logic             badv_we_q, badv_we_d;
  logic             bd_q, bd_d;

  logic             hit, is_eret, use_badv_d, commit_go;
  logic [EXC_W-1:0] code;
  logic [31:0]      cause_eff;
  logic             unused_cp0;

  exc_prio_enc #(.EXC_W(EXC_W)) u_enc (
    .flags      (exc_flags),
    .int_pend   (int_pend_q),
`ifdef EXC_TRAP_EN
    .trap       (trap),
`endif
    .hit        (hit),
    .is_eret    (is_eret),
    .code       (code),
    .use_badv_d (use_badv_d)
  );

  assign unused_cp0 = ^{cp0_status, cause_eff};

  // Next-state, capture and commit-output logic
  always_comb begin
    state_d       = state_q;
    blank_d       = 1'b0;
    commit_go     = 1'b0;
    lat_eret_d    = lat_eret_q;
    lat_code_d    = lat_code_q;
    lat_epc_d     = lat_epc_q;
    lat_badv_d    = lat_badv_q;
    lat_badv_we_d = lat_badv_we_q;
    lat_bd_d      = lat_bd_q;
    flush_d       = 1'b0;
    cp0_we_d      = 1'b0;
    eret_d        = 1'b0;
    exccode_d     = '0;
    epc_d         = '0;
    badvaddr_d    = '0;
    badv_we_d     = 1'b0;
    bd_d          = 1'b0;

    cause_eff = cp0_cause;
`ifdef EXC_TRAP_EN
    cause_eff[15] = cp0_cause[15] | int_timer;
`endif
    int_pend_d = (|(cause_eff[8 +: NUM_INT] & cp0_status[8 +: NUM_INT]))
                 & ~cp0_status[1] & cp0_status[0];

    case (state_q)
      IDLE: begin
        // blank_q covers the bubble still in flight after a flush
        if (inst_valid && !blank_q && hit) begin
          lat_eret_d    = is_eret;
          lat_code_d    = code;
          lat_epc_d     = in_ds ? (pc - 32'd4) : pc;
          lat_badv_d    = use_badv_d ? bad_addr_d : pc;
          lat_badv_we_d = !is_eret && ((code == EXC_W'(EXC_ADEL)) ||
                                       (code == EXC_W'(EXC_ADES)));
          lat_bd_d      = in_ds;
          if (stall) begin
            state_d = HOLD;
          end else begin
            state_d   = COMMIT;
            commit_go = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          state_d   = COMMIT;
          commit_go = 1'b1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        blank_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (commit_go) begin
      flush_d  = 1'b1;
      eret_d   = lat_eret_d;
      cp0_we_d = !lat_eret_d;
      if (!lat_eret_d) begin
        exccode_d  = lat_code_d;
        epc_d      = lat_epc_d;
        bd_d       = lat_bd_d;
        badv_we_d  = lat_badv_we_d;
        badvaddr_d = lat_badv_we_d ? lat_badv_d : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      int_pend_q    <= 1'b0;
      blank_q       <= 1'b0;
      lat_eret_q    <= 1'b0;
      lat_code_q    <= '0;
      lat_epc_q     <= '0;
      lat_badv_q    <= '0;
      lat_badv_we_q <= 1'b0;
      lat_bd_q      <= 1'b0;
      flush_q       <= 1'b0;
      cp0_we_q      <= 1'b0;
      eret_q        <= 1'b0;
      exccode_q     <= '0;
      epc_q         <= '0;
      badvaddr_q    <= '0;
      badv_we_q     <= 1'b0;
      bd_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      int_pend_q    <= int_pend_d;
      blank_q       <= blank_d;
      lat_eret_q    <= lat_eret_d;
      lat_code_q    <= lat_code_d;
      lat_epc_q     <= lat_epc_d;
      lat_badv_q    <= lat_badv_d;
      lat_badv_we_q <= lat_badv_we_d;
      lat_bd_q      <= lat_bd_d;
      flush_q       <= flush_d;
      cp0_we_q      <= cp0_we_d;
      eret_q        <= eret_d;
      exccode_q     <= exccode_d;
      epc_q         <= epc_d;
      badvaddr_q    <= badvaddr_d;
      badv_we_q     <= badv_we_d;
      bd_q          <= bd_d;
    end
  end

  // ERET target follows the live EPC during the commit cycle
  assign new_pc     = flush_q ? (eret_q ? cp0_epc : EXC_VEC) : '0;
  assign flush      = flush_q;
  assign cp0_we     = cp0_we_q;
  assign eret_o     = eret_q;
  assign exccode    = exccode_q;
  assign epc_o      = epc_q;
  assign badvaddr_o = badvaddr_q;
  assign badv_we    = badv_we_q;
  assign bd_o       = bd_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl with an expected-commit scoreboard.
module tb_exc_ctrl;

  localparam logic [31:0] VEC       = 32'hBFC00380;
  localparam logic [7:0]  F_ADES    = 8'h01;
  localparam logic [7:0]  F_ADEL_D  = 8'h02;
  localparam logic [7:0]  F_OV      = 8'h04;
  localparam logic [7:0]  F_BRK     = 8'h08;
  localparam logic [7:0]  F_SYS     = 8'h10;
  localparam logic [7:0]  F_RI      = 8'h20;
  localparam logic [7:0]  F_ADEL_IF = 8'h40;
  localparam logic [7:0]  F_ERET    = 8'h80;

  logic        clk = 1'b0;
  logic        resetn, inst_valid, stall, in_ds;
  logic [31:0] pc, bad_addr_d, cp0_status, cp0_cause, cp0_epc;
  logic [7:0]  exc_flags;
`ifdef EXC_TRAP_EN
  logic        trap, int_timer;
`endif
  logic        flush, cp0_we, badv_we, bd_o, eret_o;
  logic [31:0] new_pc, epc_o, badvaddr_o;
  logic [4:0]  exccode;

  typedef struct {
    int unsigned cyc;
    logic        eret;
    logic [4:0]  code;
    logic [31:0] epc;
    logic [31:0] badv;
    logic        badv_we;
    logic        bd;
    logic [31:0] npc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc    = 0;
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  exc_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .inst_valid (inst_valid),
    .stall      (stall),
    .pc         (pc),
    .in_ds      (in_ds),
    .exc_flags  (exc_flags),
    .bad_addr_d (bad_addr_d),
    .cp0_status (cp0_status),
    .cp0_cause  (cp0_cause),
    .cp0_epc    (cp0_epc),
`ifdef EXC_TRAP_EN
    .trap       (trap),
    .int_timer  (int_timer),
`endif
    .flush      (flush),
    .new_pc     (new_pc),
    .cp0_we     (cp0_we),
    .exccode    (exccode),
    .epc_o      (epc_o),
    .badvaddr_o (badvaddr_o),
    .badv_we    (badv_we),
    .bd_o       (bd_o),
    .eret_o     (eret_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned d, input logic eret, input logic [4:0] code,
                      input logic [31:0] epc, input logic [31:0] badv,
                      input logic badv_we, input logic bd, input logic [31:0] npc);
    exp_t e;
    e.cyc = cyc + d; e.eret = eret; e.code = code; e.epc = epc;
    e.badv = badv; e.badv_we = badv_we; e.bd = bd; e.npc = npc;
    sb.push_back(e);
  endtask

  // Every cycle: either the head commit is due and must match, or nothing commits
  task automatic monitor();
    exp_t e;
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check("flush", 32'(flush), 32'd1);
      check("eret_o", 32'(eret_o), 32'(e.eret));
      check("cp0_we", 32'(cp0_we), 32'(!e.eret));
      check("new_pc", new_pc, e.npc);
      if (!e.eret) begin
        check("exccode", 32'(exccode), 32'(e.code));
        check("epc_o", epc_o, e.epc);
        check("bd_o", 32'(bd_o), 32'(e.bd));
        check("badv_we", 32'(badv_we), 32'(e.badv_we));
        if (e.badv_we) check("badvaddr_o", badvaddr_o, e.badv);
      end
    end else begin
      check("idle_flush", 32'(flush), 32'd0);
      check("idle_cp0_we", 32'(cp0_we), 32'd0);
      check("idle_eret_o", 32'(eret_o), 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_flush"}, 32'(flush), 32'd0);
    check({tag, "_new_pc"}, new_pc, 32'd0);
    check({tag, "_cp0_we"}, 32'(cp0_we), 32'd0);
    check({tag, "_exccode"}, 32'(exccode), 32'd0);
    check({tag, "_epc_o"}, epc_o, 32'd0);
    check({tag, "_badvaddr_o"}, badvaddr_o, 32'd0);
    check({tag, "_badv_we"}, 32'(badv_we), 32'd0);
    check({tag, "_bd_o"}, 32'(bd_o), 32'd0);
    check({tag, "_eret_o"}, 32'(eret_o), 32'd0);
  endtask

  // One instruction with an exception, unstalled; commit due one cycle later
  task automatic single(input logic [7:0] f, input logic [31:0] p, input logic ds,
                        input logic [31:0] bad, input logic [4:0] code,
                        input logic [31:0] epc, input logic [31:0] badv, input logic bwe);
    push(1, 1'b0, code, epc, badv, bwe, ds, VEC);
    exc_flags = f; pc = p; in_ds = ds; bad_addr_d = bad; inst_valid = 1'b1;
    step();
    inst_valid = 1'b0; exc_flags = 8'h00; in_ds = 1'b0;
    step();
    step();
  endtask

  initial begin
    resetn = 1'b0; inst_valid = 1'b0; stall = 1'b0; in_ds = 1'b0;
    pc = '0; bad_addr_d = '0; cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
    exc_flags = 8'h00;
`ifdef EXC_TRAP_EN
    trap = 1'b0; int_timer = 1'b0;
`endif
    step();
    step();
    chk_all_zero("reset");
    resetn = 1'b1;
    step();

    // Overflow commit, then delay-slot load address error
    single(F_OV, 32'hBFC00100, 1'b0, 32'h0, 5'h0c, 32'hBFC00100, 32'h0, 1'b0);
    single(F_ADEL_D, 32'h80001004, 1'b1, 32'h80000003, 5'h04, 32'h80001000, 32'h80000003, 1'b1);

    // Remaining single sources, including pc-4 wraparound in a delay slot
    single(F_SYS, 32'h80000100, 1'b0, 32'hDEAD0000, 5'h08, 32'h80000100, 32'h0, 1'b0);
    single(F_BRK, 32'h80000104, 1'b1, 32'hDEAD0000, 5'h09, 32'h80000100, 32'h0, 1'b0);
    single(F_ADES, 32'h80000200, 1'b0, 32'h00001001, 5'h05, 32'h80000200, 32'h00001001, 1'b1);
    single(F_ADEL_IF, 32'h00000000, 1'b1, 32'h55555555, 5'h04, 32'hFFFFFFFC, 32'h00000000, 1'b1);
    single(F_OV | F_SYS | F_ADEL_D, 32'h80000300, 1'b0, 32'h7, 5'h0c, 32'h80000300, 32'h0, 1'b0);

    // ri beats ades; held 3 stalled cycles while a different event is ignored
    push(4, 1'b0, 5'h0a, 32'h80002000, 32'h0, 1'b0, 1'b0, VEC);
    exc_flags = F_RI | F_ADES; pc = 32'h80002000; bad_addr_d = 32'h12345678;
    inst_valid = 1'b1; stall = 1'b1;
    step();
    exc_flags = F_SYS; pc = 32'h90000000; in_ds = 1'b1;
    step();
    step();
    stall = 1'b0; inst_valid = 1'b0; exc_flags = 8'h00; in_ds = 1'b0;
    step();
    step();
    step();

    // Interrupt waits for a valid instruction
    cp0_status = 32'h00000401; cp0_cause = 32'h00000400;
    step();
    step();
    push(1, 1'b0, 5'h00, 32'h80000020, 32'h0, 1'b0, 1'b0, VEC);
    inst_valid = 1'b1; pc = 32'h80000020;
    step();
    inst_valid = 1'b0; cp0_cause = 32'h0;
    step();
    step();

    // EXL set masks the interrupt
    cp0_status = 32'h00000403; cp0_cause = 32'h00000400;
    step();
    step();
    inst_valid = 1'b1; pc = 32'h80000040;
    step();
    inst_valid = 1'b0;
    step();
    step();
    cp0_status = 32'h0; cp0_cause = 32'h0;
    step();

    // ERET redirects to the live EPC
    cp0_epc = 32'h80000444;
    push(1, 1'b1, 5'h00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h80000444);
    exc_flags = F_ERET; pc = 32'h80000500; inst_valid = 1'b1;
    step();
    inst_valid = 1'b0; exc_flags = 8'h00;
    step();
    step();

    // Reset while holding aborts the pending commit
    exc_flags = F_BRK; pc = 32'h80000600; inst_valid = 1'b1; stall = 1'b1;
    step();
    inst_valid = 1'b0; exc_flags = 8'h00; stall = 1'b0; resetn = 1'b0;
    step();
    chk_all_zero("rst_hold");
    resetn = 1'b1;
    step();
    step();

    // Events in the commit cycle and the bubble after it are dropped
    push(1, 1'b0, 5'h0a, 32'h80000700, 32'h0, 1'b0, 1'b0, VEC);
    exc_flags = F_RI; pc = 32'h80000700; inst_valid = 1'b1;
    step();
    exc_flags = F_SYS; pc = 32'h80000704;
    step();
    step();
    inst_valid = 1'b0; exc_flags = 8'h00;
    step();
    step();

`ifdef EXC_TRAP_EN
    trap = 1'b1;
    single(F_SYS | F_BRK, 32'h80000800, 1'b0, 32'h0, 5'h0d, 32'h80000800, 32'h0, 1'b0);
    trap = 1'b0;
`endif

    step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Parametrised, registered successor to the combinational exception-type encoder in the MIPS core.
- Sits at the MEM/WB boundary. Collects per-instruction exception flags and the pending interrupt state, prioritises them, and commits one exception per event.
- Commit produces a one-cycle flush, the redirect PC, and the CP0 update strobe (EPC/BadVAddr/Cause.ExcCode/BD).
- Holds a commit across pipeline stalls and handles ERET.

Parameters:
- NUM_INT, 8, number of interrupt lines (Cause/Status IP/IM bits [8 +: NUM_INT]).
- EXC_VEC, 32'hBFC00380, general exception vector.
- EXC_W, 5, width of the ExcCode field.

Ports:
- clk  in  1  core clock
- resetn  in  1  synchronous reset, active-low
- inst_valid  in  1  MEM-stage instruction valid
- stall  in  1  pipeline stalled; nothing may commit
- pc  in  32  MEM-stage PC
- in_ds  in  1  MEM-stage instruction is in a delay slot
- exc_flags  in  8  {eret, adel_if, ri, syscall, brk, ov, adel_d, ades}
- bad_addr_d  in  32  data address of the load/store
- cp0_status  in  32  CP0 Status
- cp0_cause  in  32  CP0 Cause
- cp0_epc  in  32  CP0 EPC
- flush  out  1  one-cycle pipeline flush
- new_pc  out  32  redirect target, valid with flush
- cp0_we  out  1  one-cycle CP0 exception-update strobe
- exccode  out  EXC_W  ExcCode to write
- epc_o  out  32  EPC to write
- badvaddr_o  out  32  BadVAddr to write
- badv_we  out  1  BadVAddr write enable
- bd_o  out  1  Cause.BD value
- eret_o  out  1  clear Status.EXL

Behaviour:
- Reset (resetn=0 at a clk edge): every output 0; state IDLE; int_pend=0.
- Interrupt sampling:
  - int_pend <= |(cause[8+:NUM_INT] & status[8+:NUM_INT]) & ~status[1] & status[0], every cycle.
  - The interrupt is attached to the next instruction with inst_valid=1.
- Priority, highest first:
  - int_pend → 0x00
  - adel_if → 0x04, badvaddr=pc
  - ri → 0x0a
  - ov → 0x0c
  - syscall → 0x08
  - brk → 0x09
  - adel_d → 0x04, badvaddr=bad_addr_d
  - ades → 0x05, badvaddr=bad_addr_d
  - eret → ERET
- States IDLE, HOLD, COMMIT:
  - IDLE: on inst_valid && any event:
    - Latch code, pc, in_ds, badvaddr.
    - stall=1 → HOLD; else → COMMIT.
  - HOLD: latched values frozen; new inputs ignored; stall=0 → COMMIT.
  - COMMIT: single cycle; flush=1, cp0_we=1 (eret_o=1 instead for ERET); then back to IDLE.
- Commit outputs:
  - epc_o = in_ds ? pc-4 : pc (32-bit wrap).
  - bd_o = in_ds.
  - new_pc = EXC_VEC, or cp0_epc for ERET. cp0_epc is sampled in COMMIT.
  - badv_we = 1 only for 0x04/0x05.
- Latency: event accepted in IDLE with no stall → flush exactly 1 cycle later.
- Flush blanking:
  - inst_valid is ignored in COMMIT.
  - inst_valid is also ignored on the cycle after COMMIT, because the flushed pipeline still carries a bubble.
  - No back-to-back commits.
- Interrupt with no valid instruction: waits; EPC is always a real instruction's PC.
- Reset mid-HOLD/COMMIT: abort; no flush; outputs 0.

Optional Feature:
- Macro EXC_TRAP_EN.
- Defined:
  - Adds input trap (1 bit), priority between ov and syscall, ExcCode 0x0d.
  - Adds input int_timer, ORed into the IP7 term of the interrupt computation.
- Undefined:
  - Neither port exists.
  - 0x0d is never produced.

Decomposition:
- Shared package cpu_defs_pkg:
  - ExcCode localparams EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_OV=12, EXC_TR=13.
  - exc_flags bit-index constants.
  - State enum {IDLE, HOLD, COMMIT}.
- Sub-module exc_prio_enc: combinational priority encoder (flags, int_pend) → {hit, is_eret, code, use_badv_d}.

Test Plan:
- Test 1, overflow commit:
  - Stimulus: ov=1, pc=0xBFC00100, in_ds=0, stall=0.
  - Next cycle: flush=1, cp0_we=1, exccode=0x0c, epc_o=0xBFC00100, new_pc=0xBFC00380, badv_we=0.
- Test 2, delay-slot load address error:
  - Stimulus: adel_d=1, bad_addr_d=0x80000003, pc=0x80001004, in_ds=1.
  - Response: exccode=0x04, epc_o=0x80001000, bd_o=1, badvaddr_o=0x80000003, badv_we=1.
- Test 3, priority and stall:
  - Stimulus: ri and ades together, stall held 3 cycles.
  - Response: exccode=0x0a; flush on the cycle after stall drops; no flush during the stall.
- Test 4, interrupt:
  - Stimulus: status=0x00000401, cause IP2 set, idle 2 cycles with no valid instruction, then inst_valid at pc=0x80000020.
  - Response: exccode=0x00, epc_o=0x80000020.
  - Repeat with status[1]=1 → no commit.
- Test 5, ERET:
  - Stimulus: eret=1, cp0_epc=0x80000444.
  - Response: flush=1, eret_o=1, cp0_we=0, new_pc=0x80000444.
- Test 6, reset and blanking:
  - Reset asserted while in HOLD → no flush, all outputs 0.
  - After a commit, an event on the next cycle is ignored.
  - With EXC_TRAP_EN defined, trap → exccode 0x0d.
